cmd_proc: RTL

//  Command processor sitting directly downstream of the UART wrapper. Consumes each 16-bit host

---
 rtl/rasm_cmd_pkg.sv | 29 ++
 rtl/cmd_proc_if.sv | 21 ++
 rtl/cmd_proc.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rasm_cmd_pkg.sv
// Shared types and constants for the robot-arm command processor.
package rasm_cmd_pkg;

    typedef enum logic [3:0] {
        OP_SET_POS = 4'd1,
        OP_MOVE    = 4'd2,
        OP_CAL     = 4'd3,
        OP_STATUS  = 4'd4
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        WAIT_MOVE,
        WAIT_CAL,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [7:0] ACK        = 8'hA5;
    localparam logic [7:0] NACK       = 8'h5A;
    localparam logic [7:0] TMO        = 8'hEE;
    localparam logic [3:0] STATUS_TAG = 4'hC;

    function automatic logic [7:0] status_byte(input logic cal_ok, input logic last_tmo);
        return {STATUS_TAG, cal_ok, last_tmo, 2'b00};
    endfunction

endpackage

// File: rtl/cmd_proc_if.sv
// Host-side handshake between the UART wrapper (master) and the command processor (slave).
interface cmd_proc_if;

    logic        cmd_rdy;
    logic [15:0] cmd;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    modport master (
        output cmd_rdy, cmd, resp_sent,
        input  clr_cmd_rdy, send_resp, resp
    );

    modport slave (
        input  cmd_rdy, cmd, resp_sent,
        output clr_cmd_rdy, send_resp, resp
    );

endinterface

// File: rtl/cmd_proc.sv
// Command processor: decodes host commands, updates joint targets, sequences move/calibrate
// with a timeout, and returns exactly one response byte per command.
module cmd_proc
    import rasm_cmd_pkg::*;
#(
    parameter int               POS_W   = 10,
    parameter int               TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_CYC = 24'd5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_proc_if.slave          host,
    output logic [4*POS_W-1:0] tgt_pos,
    output logic               strt_move,
    input  logic               move_done,
    output logic               strt_cal,
    input  logic               cal_done,
    output logic               busy
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

    state_t             state_q, state_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [POS_W-1:0]   tgt_q [4];
    logic [POS_W-1:0]   tgt_d [4];
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]         resp_q, resp_d;
    logic               cal_ok_q, cal_ok_d;
    logic               last_tmo_q, last_tmo_d;
    logic               wait_done;

    // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        tgt_d            = tgt_q;
        tmo_cnt_d        = tmo_cnt_q;
        resp_d           = resp_q;
        cal_ok_d         = cal_ok_q | cal_done;
        last_tmo_d       = last_tmo_q;
        wait_done        = 1'b0;
        host.clr_cmd_rdy = 1'b0;
        host.send_resp   = 1'b0;
        strt_move        = 1'b0;
        strt_cal         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (host.cmd_rdy) begin
                    cmd_d            = host.cmd;
                    host.clr_cmd_rdy = 1'b1;
                    state_d          = DISPATCH;
                end
            end
            DISPATCH: begin
                case (cmd_q[15:12])
                    OP_SET_POS: begin
                        tgt_d[cmd_q[11:10]] = cmd_q[POS_W-1:0];
                        resp_d              = ACK;
                        last_tmo_d          = 1'b0;
                        state_d             = SEND;
                    end
                    OP_MOVE: begin
                        strt_move = 1'b1;
                        tmo_cnt_d = '0;
                        state_d   = WAIT_MOVE;
                    end
                    OP_CAL: begin
                        strt_cal  = 1'b1;
                        tmo_cnt_d = '0;
                        state_d   = WAIT_CAL;
                    end
                    OP_STATUS: begin
                        resp_d  = status_byte(cal_ok_q, last_tmo_q);
                        state_d = SEND;
                    end
                    default: begin
                        resp_d  = NACK;
                        state_d = SEND;
                    end
                endcase
            end
            WAIT_MOVE, WAIT_CAL: begin
                // The counter leaves this state at TMO_LAST, so it can never wrap.
                wait_done = (state_q == WAIT_MOVE) ? move_done : cal_done;
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (wait_done) begin
                    resp_d     = ACK;
                    last_tmo_d = 1'b0;
                    state_d    = SEND;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    resp_d     = TMO;
                    last_tmo_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                host.send_resp = 1'b1;
                state_d        = WAIT_TX;
            end
            WAIT_TX: begin
                if (host.resp_sent) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the target array is a tiny
    // register file and takes the async reset like everything else, so a reset clears targets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            tmo_cnt_q  <= '0;
            resp_q     <= '0;
            cal_ok_q   <= 1'b0;
            last_tmo_q <= 1'b0;
            for (int j = 0; j < 4; j++) tgt_q[j] <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tmo_cnt_q  <= tmo_cnt_d;
            resp_q     <= resp_d;
            cal_ok_q   <= cal_ok_d;
            last_tmo_q <= last_tmo_d;
            tgt_q      <= tgt_d;
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_tgt
        assign tgt_pos[j*POS_W +: POS_W] = tgt_q[j];
    end

    assign host.resp = resp_q;
    assign busy      = (state_q != IDLE);

endmodule
